// File: rtl/spi_master_if.sv
// Bundle of the spi_master user handshake and SPI pin signals.
// The master modport is the view taken by spi_master itself; the slave
// modport is the view of whoever sits on the other side (user logic plus
// the SPI slave pins).
interface spi_master_if #(
    parameter int WIDTH = 13
) ();

    logic             start;
    logic [WIDTH-1:0] tx_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] rx_data;
    logic             sclk;
    logic             mosi;
    logic             load;
    logic             miso;

    modport master (
        input  start, tx_data, miso,
        output busy, done, rx_data, sclk, mosi, load
    );

    modport slave (
        output start, tx_data, miso,
        input  busy, done, rx_data, sclk, mosi, load
    );

endinterface

// File: rtl/spi_master.sv
// SPI master for the team's WIDTH-bit SPI slave.
// A frame is: load pulse (slave parallel-loads its TX word), WIDTH full-duplex
// bits MSB first, a second load pulse (slave commits its RX word), then the
// word shifted in from miso is presented on rx_data with a one-cycle done.
// Every output comes straight from a flop; the combinational process only
// computes next-state values.
module spi_master #(
    parameter int WIDTH   = 13,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              clr,
    spi_master_if.master      bus
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PRE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD_POST
    } state_e;

    state_e             state_q,   state_d;
    logic [DIV_W-1:0]   divCnt_q,  divCnt_d;
    logic [BIT_W-1:0]   bitCnt_q,  bitCnt_d;
    logic [WIDTH-1:0]   txShift_q, txShift_d;
    logic [WIDTH-1:0]   rxShift_q, rxShift_d;
    logic [WIDTH-1:0]   rxData_q,  rxData_d;
    logic               sclk_q,    sclk_d;
    logic               load_q,    load_d;
    logic               mosi_q,    mosi_d;
    logic               busy_q,    busy_d;
    logic               done_q,    done_d;
    logic               phaseEnd;

    // The current state (or load pulse) has lasted its full CLK_DIV cycles.
    assign phaseEnd = (divCnt_q == DIV_LAST);

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rxData_q;
    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.load    = load_q;

    // State and output registers; clr returns everything to idle values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            divCnt_q  <= '0;
            bitCnt_q  <= '0;
            txShift_q <= '0;
            rxShift_q <= '0;
            rxData_q  <= '0;
            sclk_q    <= 1'b0;
            load_q    <= 1'b0;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            divCnt_q  <= divCnt_d;
            bitCnt_q  <= bitCnt_d;
            txShift_q <= txShift_d;
            rxShift_q <= rxShift_d;
            rxData_q  <= rxData_d;
            sclk_q    <= sclk_d;
            load_q    <= load_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Frame sequencing; sclk/load/busy are decoded from the next state so
    // their flops always line up with the state the FSM is entering.
    always_comb begin
        state_d   = state_q;
        divCnt_d  = divCnt_q;
        bitCnt_d  = bitCnt_q;
        txShift_d = txShift_q;
        rxShift_d = rxShift_q;
        rxData_d  = rxData_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                divCnt_d = '0;
                if (bus.start) begin
                    txShift_d = bus.tx_data;
                    rxShift_d = '0;
                    bitCnt_d  = '0;
                    state_d   = LOAD_PRE;
                end
            end

            LOAD_PRE: begin
                divCnt_d = divCnt_q + 1'b1;
                if (phaseEnd) begin
                    divCnt_d = '0;
                    mosi_d   = txShift_q[WIDTH-1];
                    bitCnt_d = '0;
                    state_d  = SHIFT_LO;
                end
            end

            SHIFT_LO: begin
                divCnt_d = divCnt_q + 1'b1;
                if (phaseEnd) begin
                    divCnt_d  = '0;
                    rxShift_d = {rxShift_q[WIDTH-2:0], bus.miso};
                    state_d   = SHIFT_HI;
                end
            end

            SHIFT_HI: begin
                divCnt_d = divCnt_q + 1'b1;
                if (phaseEnd) begin
                    divCnt_d = '0;
                    if (bitCnt_q != BIT_LAST) begin
                        txShift_d = txShift_q << 1;
                        mosi_d    = txShift_q[WIDTH-2];
                        bitCnt_d  = bitCnt_q + 1'b1;
                        state_d   = SHIFT_LO;
                    end else begin
                        state_d   = LOAD_POST;
                    end
                end
            end

            LOAD_POST: begin
                divCnt_d = divCnt_q + 1'b1;
                if (phaseEnd) begin
                    divCnt_d = '0;
                    rxData_d = rxShift_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: begin
                divCnt_d = '0;
                state_d  = IDLE;
            end
        endcase

        sclk_d = (state_d == SHIFT_HI);
        load_d = (state_d == LOAD_PRE) || (state_d == LOAD_POST);
        busy_d = (state_d != IDLE);
    end

endmodule
